// File: rtl/rrc_pkg.sv
// Shared constants for the root-raised-cosine transmit path: default sizes,
// the quantised RRC taps and the PRBS bit to symbol sign mapping.
package rrc_pkg;

    localparam int NBAUDS_DEF   = 6;
    localparam int OS_DEF       = 4;
    localparam int NB_COEF_DEF  = 8;
    localparam int NBF_COEF_DEF = 7;
    localparam int NTAPS_DEF    = NBAUDS_DEF * OS_DEF;

    // PRBS bit 0 transmits +1, bit 1 transmits -1.
    typedef enum logic {
        SYM_POS = 1'b0,
        SYM_NEG = 1'b1
    } sym_sign_e;

    // Roll-off 0.5, S(8,7). Tap n lives at bits [n*8 +: 8]; the table is
    // symmetric so listing order is the same either way.
    localparam logic [NTAPS_DEF*NB_COEF_DEF-1:0] RRC_COEF_FLAT = {
        8'hFF, 8'hFE, 8'h00, 8'h03, 8'h04, 8'hFE,
        8'hF4, 8'hF1, 8'h00, 8'h22, 8'h4C, 8'h69,
        8'h69, 8'h4C, 8'h22, 8'h00, 8'hF1, 8'hF4,
        8'hFE, 8'h04, 8'h03, 8'h00, 8'hFE, 8'hFF
    };

endpackage

// File: rtl/rrc_sat_trunc.sv
// Floor-truncates a full-precision accumulator by SHIFT LSBs and saturates
// the result into a signed NB_OUT-bit word.
module rrc_sat_trunc #(
    parameter int NB_IN  = 11,
    parameter int NB_OUT = 8,
    parameter int SHIFT  = 0
) (
    input  logic signed [NB_IN-1:0]  data_i,
    output logic signed [NB_OUT-1:0] data_o
);

    logic signed [NB_IN-1:0] shifted;

    assign shifted = data_i >>> SHIFT;

    generate
        if (NB_IN - SHIFT > NB_OUT) begin : g_sat
            localparam logic signed [NB_IN-1:0] MAX_V = NB_IN'((2 ** (NB_OUT - 1)) - 1);
            localparam logic signed [NB_IN-1:0] MIN_V = -MAX_V - NB_IN'(1);

            always_comb begin
                if (shifted > MAX_V) begin
                    data_o = NB_OUT'(MAX_V);
                end else if (shifted < MIN_V) begin
                    data_o = NB_OUT'(MIN_V);
                end else begin
                    data_o = NB_OUT'(shifted);
                end
            end
        end else begin : g_pass
            assign data_o = NB_OUT'(shifted);
        end
    endgenerate

endmodule

// File: rtl/tx_rrc_polyphase.sv
// Polyphase RRC transmit filter for one rail: equivalent to zero-stuffing by OS
// followed by the full FIR, but only the NBAUDS taps of the current phase are summed.
module tx_rrc_polyphase
    import rrc_pkg::*;
#(
    parameter int NBAUDS   = NBAUDS_DEF,
    parameter int OS       = OS_DEF,
    parameter int NB_COEF  = NB_COEF_DEF,
    parameter int NBF_COEF = NBF_COEF_DEF,
    parameter int NB_OUT   = 8,
    parameter int NBF_OUT  = 7,
    parameter logic [NBAUDS*OS*NB_COEF-1:0] COEF_FLAT = RRC_COEF_FLAT,
    localparam int PHW = (OS > 1) ? $clog2(OS) : 1
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_symbol,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic                     o_valid,
    output logic [PHW-1:0]           o_phase
);

    localparam int ACC_W = NB_COEF + $clog2(NBAUDS);

    logic [PHW-1:0]           phase_q, phase_d;
    logic [NBAUDS-1:0]        sym_q, sym_d;
    logic [NBAUDS-1:0]        mask_q, mask_d;
    logic signed [NB_OUT-1:0] sample_q;
    logic                     valid_q;
    logic [PHW-1:0]           phase_out_q;

    logic signed [NB_COEF-1:0] tap;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc;
    logic signed [NB_OUT-1:0]  sat_out;

    // A new symbol and a mask bit enter together so unloaded taps stay silent.
    always_comb begin
        phase_d = phase_q;
        sym_d   = sym_q;
        mask_d  = mask_q;
        if (i_enable) begin
            phase_d = (phase_q == PHW'(OS - 1)) ? '0 : phase_q + PHW'(1);
            if (phase_q == '0) begin
                sym_d  = {sym_q[NBAUDS-2:0], i_symbol};
                mask_d = {mask_q[NBAUDS-2:0], 1'b1};
            end
        end
    end

    // Sum over baud taps for the current phase, using the freshly shifted symbols.
    always_comb begin
        acc  = '0;
        tap  = '0;
        term = '0;
        for (int k = 0; k < NBAUDS; k++) begin
            tap = '0;
            for (int p = 0; p < OS; p++) begin
                if (phase_q == PHW'(p)) begin
                    tap = COEF_FLAT[(k*OS + p)*NB_COEF +: NB_COEF];
                end
            end
            term = ACC_W'(tap);
            if (sym_sign_e'(sym_d[k]) == SYM_NEG) begin
                term = -term;
            end
            if (mask_d[k]) begin
                acc = acc + term;
            end
        end
    end

    rrc_sat_trunc #(
        .NB_IN  (ACC_W),
        .NB_OUT (NB_OUT),
        .SHIFT  (NBF_COEF - NBF_OUT)
    ) u_sat_trunc (
        .data_i (acc),
        .data_o (sat_out)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q     <= '0;
            sym_q       <= '0;
            mask_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            phase_out_q <= '0;
        end else begin
            phase_q <= phase_d;
            sym_q   <= sym_d;
            mask_q  <= mask_d;
            valid_q <= i_enable;
            if (i_enable) begin
                sample_q    <= sat_out;
                phase_out_q <= phase_q;
            end
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;
    assign o_phase  = phase_out_q;

endmodule

// File: tb/tb_tx_rrc_polyphase.sv
// Directed bench for tx_rrc_polyphase: ramp, real-RRC and truncating/saturating
// instances share one stimulus stream; a zero-stuffed FIR model covers long random runs.
module tb_tx_rrc_polyphase;

    localparam int NTAPS = 24;

    function automatic logic [NTAPS*8-1:0] makeFlat(input int constVal);
        logic [NTAPS*8-1:0] v;
        v = '0;
        for (int n = 0; n < NTAPS; n++) begin
            v[n*8 +: 8] = (constVal == 0) ? 8'(n + 1) : 8'(constVal);
        end
        return v;
    endfunction

    localparam logic [NTAPS*8-1:0] RAMP_FLAT = makeFlat(0);
    localparam logic [NTAPS*8-1:0] SAT_FLAT  = makeFlat(101);

    logic clk;
    logic rstN;
    logic enable;
    logic symbol;

    logic signed [7:0] rampSample, realSample, satSample;
    logic              rampValid, realValid, satValid;
    logic [1:0]        rampPhase, realPhase, satPhase;

    int checkCount = 0;
    int passCount  = 0;

    int realH [NTAPS] = '{-1, -2, 0, 3, 4, -2, -12, -15, 0, 34, 76, 105,
                          105, 76, 34, 0, -15, -12, -2, 4, 3, 0, -2, -1};
    int impulseExp [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
    int rampFull [4]   = '{66, 72, 78, 84};
    int realFull [4]   = '{96, 94, 94, 96};

    int   xh [NTAPS];
    int   mph;
    int   nSym;
    int   yReal;
    int   ySat;
    logic en;
    logic sb;
    logic [5:0] pat;

    tx_rrc_polyphase #(.NB_OUT(8), .NBF_OUT(7), .COEF_FLAT(RAMP_FLAT)) uRamp (
        .clk(clk), .i_rst_n(rstN), .i_enable(enable), .i_symbol(symbol),
        .o_sample(rampSample), .o_valid(rampValid), .o_phase(rampPhase)
    );

    tx_rrc_polyphase uReal (
        .clk(clk), .i_rst_n(rstN), .i_enable(enable), .i_symbol(symbol),
        .o_sample(realSample), .o_valid(realValid), .o_phase(realPhase)
    );

    tx_rrc_polyphase #(.NB_OUT(8), .NBF_OUT(5), .COEF_FLAT(SAT_FLAT)) uSat (
        .clk(clk), .i_rst_n(rstN), .i_enable(enable), .i_symbol(symbol),
        .o_sample(satSample), .o_valid(satValid), .o_phase(satPhase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic enIn, input logic symIn);
        @(negedge clk);
        enable = enIn;
        symbol = symIn;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rstN   = 1'b0;
        enable = 1'b0;
        symbol = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    function automatic int clip8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    initial begin
        rstN   = 1'b0;
        enable = 1'b0;
        symbol = 1'b0;
        #1;
        checkOutput("reset_sample", rampSample, 0);
        checkOutput("reset_valid", rampValid, 0);
        checkOutput("reset_phase", rampPhase, 0);
        checkOutput("reset_sat_sample", satSample, 0);
        @(negedge clk);
        rstN = 1'b1;

        // Impulse: symbol 0 then a run of 1s.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i == 0) ? 1'b0 : 1'b1);
            checkOutput("impulse_sample", rampSample, impulseExp[i]);
            checkOutput("impulse_phase", rampPhase, i % 4);
            checkOutput("impulse_valid", rampValid, 1);
            if (i == 0) checkOutput("trunc_pos_first", satSample, 25);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_valid", rampValid, 0);
        checkOutput("idle_hold", rampSample, 4);

        // Full load with all symbols 0.
        resetDut();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i >= 24) begin
                checkOutput("full_ramp", rampSample, rampFull[i % 4]);
                checkOutput("full_real", realSample, realFull[i % 4]);
            end
            if (i == 16) checkOutput("sat_pos_five", satSample, 126);
            if (i == 20) checkOutput("sat_pos_clip", satSample, 127);
            if (i == 24) checkOutput("sat_pos_hold", satSample, 127);
        end

        // Full load with all symbols 1.
        resetDut();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (i == 0) checkOutput("trunc_neg_first", satSample, -26);
            if (i >= 24) begin
                checkOutput("full_ramp_neg", rampSample, -rampFull[i % 4]);
                checkOutput("full_real_neg", realSample, -realFull[i % 4]);
            end
            if (i == 16) checkOutput("sat_neg_five", satSample, -127);
            if (i == 20) checkOutput("sat_neg_clip", satSample, -128);
        end

        // Worst-case sign pattern on the real taps: +128 clips, -128 is exact.
        pat = 6'b100010;
        resetDut();
        for (int i = 0; i < 21; i++) applyStimulus(1'b1, pat[i/4]);
        checkOutput("real_max_clip", realSample, 127);
        pat = 6'b011101;
        resetDut();
        for (int i = 0; i < 21; i++) applyStimulus(1'b1, pat[i/4]);
        checkOutput("real_min_exact", realSample, -128);

        // Enable every third cycle, symbol toggling while ignored.
        resetDut();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i == 0) ? 1'b0 : ((i == 4) ? 1'b1 : 1'(i % 2)));
            checkOutput("gap_sample", rampSample, impulseExp[i]);
            checkOutput("gap_phase", rampPhase, i % 4);
            checkOutput("gap_valid", rampValid, 1);
            for (int g = 0; g < 2; g++) begin
                applyStimulus(1'b0, ~symbol);
                checkOutput("gap_idle_valid", rampValid, 0);
                checkOutput("gap_idle_hold", rampSample, impulseExp[i]);
            end
        end

        // Asynchronous reset in the middle of a symbol.
        resetDut();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrst_sample", rampSample, 0);
        checkOutput("midrst_valid", rampValid, 0);
        checkOutput("midrst_phase", rampPhase, 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkOutput("midrst_first", rampSample, -1);
        checkOutput("midrst_first_phase", rampPhase, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_p1", rampSample, -2);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_p3", rampSample, -4);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_next_sym", rampSample, -4);

        // Random PRBS against a zero-stuffed FIR model.
        resetDut();
        for (int j = 0; j < NTAPS; j++) xh[j] = 0;
        mph  = 0;
        nSym = 0;
        while (nSym < 10000) begin
            en = ($urandom_range(0, 4) != 0);
            sb = 1'($urandom_range(0, 1));
            applyStimulus(en, sb);
            if (en) begin
                for (int j = NTAPS - 1; j > 0; j--) xh[j] = xh[j-1];
                if (mph == 0) begin
                    xh[0] = sb ? -1 : 1;
                    nSym++;
                end else begin
                    xh[0] = 0;
                end
                yReal = 0;
                ySat  = 0;
                for (int j = 0; j < NTAPS; j++) begin
                    yReal += realH[j] * xh[j];
                    ySat  += 101 * xh[j];
                end
                checkOutput("golden_real", realSample, clip8(yReal));
                checkOutput("golden_sat", satSample, clip8(ySat >>> 2));
                checkOutput("golden_phase", realPhase, mph);
                checkOutput("golden_valid", realValid, 1);
                mph = (mph + 1) % 4;
            end else begin
                checkOutput("golden_idle", realValid, 0);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
